ring_token_monitor: RTL and testbench

Receive-side checker for the 8-bit one-hot rotating ring register. It samples the ring's parallel output alongside the same `shift` strobe that advances the ring, and encodes the token position to a binary index. It verifies every step: exactly one hot bit, advancing by exactly one position per shift, and never moving without a shift. It also counts completed revolutions, so downstream logic such as digit-select muxes and status LEDs gets a trusted index plus a sticky fault indication.

---
 rtl/ring_token_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_ring_token_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ring_token_monitor.sv
// Receive-side checker for a one-hot rotating ring: encodes the token index, verifies every step, counts revolutions.
// Optional feature macro RING_MON_REVCOUNT_EN: when undefined, revs is tied to zero and wrap detection is removed.
module ring_token_monitor #(
    parameter int WIDTH = 8,
    parameter int REV_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring,
    input  logic                     shift,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [REV_W-1:0]         revs
);

    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_STEP   = 2'b10;
    localparam logic [1:0] ERR_MOVED  = 2'b11;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    function automatic logic f_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    function automatic logic [IW-1:0] f_encode(input logic [WIDTH-1:0] v);
        logic [IW-1:0] e;
        e = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                e = IW'(i);
            end else begin
                e = e;
            end
        end
        return e;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_shift_d;
    logic [IW-1:0]   r_idx;
    logic            r_valid;
    logic            r_err;
    logic [1:0]      r_code;
    logic [IW-1:0]   w_idx_nxt;
    logic            w_valid_nxt;
    logic            w_err_nxt;
    logic [1:0]      w_code_nxt;
    logic            w_onehot;
    logic [IW-1:0]   w_enc;
    logic [IW-1:0]   w_idx_inc;
    logic [1:0]      w_fault_code;
    logic            w_fault;

    assign w_onehot  = f_onehot(ring);
    assign w_enc     = f_encode(ring);
    assign w_idx_inc = r_idx + IW'(1);
    assign w_fault   = (w_fault_code != ERR_NONE);

    // TRACK-state checks in priority order; only meaningful while tracking
    always_comb begin
        if (!w_onehot) begin
            w_fault_code = ERR_ONEHOT;
        end else if (r_shift_d && (w_enc != w_idx_inc)) begin
            w_fault_code = ERR_STEP;
        end else if (!r_shift_d && (w_enc != r_idx)) begin
            w_fault_code = ERR_MOVED;
        end else begin
            w_fault_code = ERR_NONE;
        end
    end

    // State and shift-delay registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SYNC;
            r_shift_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift_d <= shift;
        end
    end

    // Next-state logic; clr overrides any fault seen in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_SYNC;
        end else begin
            case (r_state)
                ST_SYNC:  w_state_nxt = w_onehot ? ST_TRACK : ST_SYNC;
                ST_TRACK: w_state_nxt = w_fault ? ST_FAULT : ST_TRACK;
                ST_FAULT: w_state_nxt = ST_FAULT;
                default:  w_state_nxt = ST_SYNC;
            endcase
        end
    end

    // Next values of the registered outputs; idx freezes on a fault and across clr
    always_comb begin
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;
        if (clr) begin
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b0;
            w_code_nxt  = ERR_NONE;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (w_onehot) begin
                        w_idx_nxt   = w_enc;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (w_fault) begin
                        w_valid_nxt = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = w_fault_code;
                    end else begin
                        w_idx_nxt   = w_enc;
                        w_valid_nxt = 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign idx      = r_idx;
    assign valid    = r_valid;
    assign err      = r_err;
    assign err_code = r_code;

`ifdef RING_MON_REVCOUNT_EN
    logic             w_wrap;
    logic [REV_W-1:0] r_revs;
    logic [REV_W-1:0] w_revs_nxt;

    // A wrap is a verified shift step from the last position back to zero
    assign w_wrap = (r_state == ST_TRACK) && !w_fault && r_shift_d &&
                    (r_idx == IW'(WIDTH - 1)) && (w_enc == '0);

    // Saturating revolution count; clr wins over a same-cycle wrap
    always_comb begin
        w_revs_nxt = r_revs;
        if (clr) begin
            w_revs_nxt = '0;
        end else if (w_wrap && (r_revs != '1)) begin
            w_revs_nxt = r_revs + REV_W'(1);
        end else begin
            w_revs_nxt = r_revs;
        end
    end

    // Revolution counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_revs <= '0;
        end else begin
            r_revs <= w_revs_nxt;
        end
    end

    assign revs = r_revs;
`else
    assign revs = '0;
`endif

endmodule

// File: tb/tb_ring_token_monitor.sv
// Scoreboard bench for ring_token_monitor: stimulus queues expected outputs, a monitor pops and compares after each edge.
module tb_ring_token_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ring;
    logic       shift;
    logic       clr;
    logic [2:0] idx;
    logic       valid;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] revs;

    always #5 clk = ~clk;

    ring_token_monitor #(.WIDTH(8), .REV_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ring     (ring),
        .shift    (shift),
        .clr      (clr),
        .idx      (idx),
        .valid    (valid),
        .err      (err),
        .err_code (err_code),
        .revs     (revs)
    );

    typedef struct {
        string      name;
        logic [2:0] idx;
        logic       valid;
        logic       err;
        logic [1:0] code;
        logic [7:0] revs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [7:0] er(input int n);
`ifdef RING_MON_REVCOUNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [7:0] oh(input int p);
        logic [7:0] one;
        one = 8'h01;
        return one << p;
    endfunction

    task automatic check_out(input exp_t e);
        n_checks++;
        if (idx === e.idx && valid === e.valid && err === e.err &&
            err_code === e.code && revs === e.revs) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got idx=%0d valid=%b err=%b code=%b revs=%0d, expected idx=%0d valid=%b err=%b code=%b revs=%0d",
                     e.name, $time, idx, valid, err, err_code, revs,
                     e.idx, e.valid, e.err, e.code, e.revs);
        end
    endtask

    task automatic cyc(input logic [7:0] r, input logic s, input logic c, input string nm,
                       input int ei, input logic ev, input logic ee, input logic [1:0] ec, input int erv);
        exp_t e;
        @(negedge clk);
        rst   = 1'b0;
        ring  = r;
        shift = s;
        clr   = c;
        e.name  = nm;
        e.idx   = 3'(ei);
        e.valid = ev;
        e.err   = ee;
        e.code  = ec;
        e.revs  = er(erv);
        q.push_back(e);
    endtask

    task automatic check_reset(input string nm);
        exp_t e;
        e.name  = nm;
        e.idx   = 3'd0;
        e.valid = 1'b0;
        e.err   = 1'b0;
        e.code  = 2'b00;
        e.revs  = 8'd0;
        check_out(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            check_out(q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        ring  = 8'h01;
        shift = 1'b0;
        clr   = 1'b0;
        #2;
        check_reset("reset_state");

        for (int i = 0; i < 5; i++) cyc(8'h01, 1'b0, 1'b0, "idle", 0, 1'b1, 1'b0, 2'b00, 0);

        for (int j = 0; j < 17; j++)
            cyc(oh(j % 8), 1'b1, 1'b0, "rotate", j % 8, 1'b1, 1'b0, 2'b00, int'(j >= 8) + int'(j >= 16));

        cyc(8'h02, 1'b0, 1'b0, "step_after_rot", 1, 1'b1, 1'b0, 2'b00, 2);
        cyc(8'h05, 1'b0, 1'b0, "not_onehot",     1, 1'b0, 1'b1, 2'b01, 2);
        cyc(8'h02, 1'b0, 1'b0, "fault_hold1",    1, 1'b0, 1'b1, 2'b01, 2);
        cyc(8'h02, 1'b0, 1'b0, "fault_hold2",    1, 1'b0, 1'b1, 2'b01, 2);
        cyc(8'h02, 1'b0, 1'b1, "clr_fault",      1, 1'b0, 1'b0, 2'b00, 0);
        cyc(8'h02, 1'b0, 1'b0, "resync1",        1, 1'b1, 1'b0, 2'b00, 0);

        cyc(8'h02, 1'b1, 1'b0, "pre_jump",       1, 1'b1, 1'b0, 2'b00, 0);
        cyc(8'h08, 1'b0, 1'b0, "wrong_step",     1, 1'b0, 1'b1, 2'b10, 0);
        cyc(8'h04, 1'b0, 1'b1, "clr2",           1, 1'b0, 1'b0, 2'b00, 0);
        cyc(8'h04, 1'b0, 1'b0, "resync2",        2, 1'b1, 1'b0, 2'b00, 0);
        cyc(8'h08, 1'b0, 1'b0, "move_no_shift",  2, 1'b0, 1'b1, 2'b11, 0);
        cyc(8'h08, 1'b0, 1'b1, "clr3",           2, 1'b0, 1'b0, 2'b00, 0);

        cyc(8'h08, 1'b0, 1'b0, "resync3",        3, 1'b1, 1'b0, 2'b00, 0);
        cyc(8'h05, 1'b0, 1'b1, "fault_and_clr",  3, 1'b0, 1'b0, 2'b00, 0);
        cyc(8'h00, 1'b0, 1'b0, "sync_illegal",   3, 1'b0, 1'b0, 2'b00, 0);
        cyc(8'h10, 1'b0, 1'b0, "resync4",        4, 1'b1, 1'b0, 2'b00, 0);

        for (int k = 0; k < 2404; k++)
            cyc(oh((4 + k) % 8), 1'b1, 1'b0, "sat_rot", (4 + k) % 8, 1'b1, 1'b0, 2'b00,
                (k >= 4) ? ((k - 4) / 8 + 1) : 0);

        cyc(8'h01, 1'b0, 1'b1, "clr_beats_wrap", 7, 1'b0, 1'b0, 2'b00, 0);
        cyc(8'h01, 1'b0, 1'b0, "resync5",        0, 1'b1, 1'b0, 2'b00, 0);

        for (int k = 0; k < 14; k++)
            cyc(oh(k % 8), 1'b1, 1'b0, "pre_rst", k % 8, 1'b1, 1'b0, 2'b00, int'(k >= 8));

        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("mid_rst_async");

        for (int k = 0; k < 10; k++)
            cyc(oh(k % 8), 1'b1, 1'b0, "post_rst", k % 8, 1'b1, 1'b0, 2'b00, int'(k >= 8));

        @(negedge clk);
        shift = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
